// File: rtl/alu_sequencer.sv
// alu_sequencer: registered command front-end for an external combinational ALU.
// Latency: command accepted at edge k, result/flags captured and res_valid high from edge k+SETTLE.
// Backpressure: cmd_ready only in IDLE; the result is held in RESP until res_ready, then IDLE on the same edge.
// Ports: clk/rst (async active-high); cmd_* valid/ready command in; alu_* drive regs out and
//        alu_f/alu_neg/alu_zer in; res_* valid/ready result out; acc accumulator; op_cnt completions.
module alu_sequencer #(
   parameter int WIDTH  = 16,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_opc,
   input  logic [WIDTH-1:0] cmd_m,
   input  logic [WIDTH-1:0] cmd_n,
   input  logic             cmd_c,
   input  logic             cmd_acc,
   output logic [WIDTH-1:0] alu_m,
   output logic [WIDTH-1:0] alu_n,
   output logic             alu_c,
   output logic [2:0]       alu_opc,
   input  logic [WIDTH-1:0] alu_f,
   input  logic             alu_neg,
   input  logic             alu_zer,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_neg,
   output logic             res_zer,
   output logic [WIDTH-1:0] acc,
   output logic [7:0]       op_cnt
);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   // Settle counter preload; SETTLE is limited to 1..15 so it fits in 4 bits.
   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_m_q, alu_m_d;
   logic [WIDTH-1:0] alu_n_q, alu_n_d;
   logic             alu_c_q, alu_c_d;
   logic [2:0]       alu_opc_q, alu_opc_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_neg_q, res_neg_d;
   logic             res_zer_q, res_zer_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [7:0]       op_cnt_q, op_cnt_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_m_d    = alu_m_q;
      alu_n_d    = alu_n_q;
      alu_c_d    = alu_c_q;
      alu_opc_d  = alu_opc_q;
      res_data_d = res_data_q;
      res_neg_d  = res_neg_q;
      res_zer_d  = res_zer_q;
      acc_d      = acc_q;
      op_cnt_d   = op_cnt_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               // ALU drive registers only change here, so the ALU output is stable between commands.
               alu_opc_d = cmd_opc;
               alu_n_d   = cmd_n;
               alu_c_d   = cmd_c;
               alu_m_d   = cmd_acc ? acc_q : cmd_m;
               cnt_d     = SETTLE_M1;
               state_d   = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               res_data_d = alu_f;
               res_neg_d  = alu_neg;
               res_zer_d  = alu_zer;
               acc_d      = alu_f;
               op_cnt_d   = op_cnt_q + 8'd1;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         alu_m_q    <= '0;
         alu_n_q    <= '0;
         alu_c_q    <= 1'b0;
         alu_opc_q  <= 3'd0;
         res_data_q <= '0;
         res_neg_q  <= 1'b0;
         res_zer_q  <= 1'b0;
         acc_q      <= '0;
         op_cnt_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_m_q    <= alu_m_d;
         alu_n_q    <= alu_n_d;
         alu_c_q    <= alu_c_d;
         alu_opc_q  <= alu_opc_d;
         res_data_q <= res_data_d;
         res_neg_q  <= res_neg_d;
         res_zer_q  <= res_zer_d;
         acc_q      <= acc_d;
         op_cnt_q   <= op_cnt_d;
      end
   end

   // cmd_ready is masked by rst so nothing looks acceptable while the block is held in reset.
   assign cmd_ready = (state_q == IDLE) && !rst;
   assign res_valid = (state_q == RESP);
   assign alu_m     = alu_m_q;
   assign alu_n     = alu_n_q;
   assign alu_c     = alu_c_q;
   assign alu_opc   = alu_opc_q;
   assign res_data  = res_data_q;
   assign res_neg   = res_neg_q;
   assign res_zer   = res_zer_q;
   assign acc       = acc_q;
   assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives two sequencers (SETTLE=1 and SETTLE=4) with a behavioural ALU attached.
// Latency/ordering expectations come from a command-level model (accumulator, completion count).
// Backpressure is exercised by holding res_ready low with a pending command waiting.
module tb_alu_sequencer;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   function automatic logic [15:0] alu_fn(input logic [2:0] opc, input logic [15:0] m,
                                          input logic [15:0] n, input logic c);
      case (opc)
         3'd0: return m + n + {15'b0, c};
         3'd1: return m + (n >> 1);
         3'd2: return ($signed(m) > $signed(n)) ? m : n;
         3'd3: return m * 16'd3;
         3'd4: return m & n;
         3'd5: return m | n;
         3'd6: return ~m;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- instance A: SETTLE = 1 ----------------
   logic        rst_a, cmd_valid_a, cmd_ready_a, cmd_c_a, cmd_acc_a;
   logic [2:0]  cmd_opc_a, alu_opc_a;
   logic [15:0] cmd_m_a, cmd_n_a, alu_m_a, alu_n_a, alu_f_a;
   logic        alu_c_a, alu_neg_a, alu_zer_a;
   logic        res_valid_a, res_ready_a, res_neg_a, res_zer_a;
   logic [15:0] res_data_a, acc_a;
   logic [7:0]  op_cnt_a;

   assign alu_f_a   = alu_fn(alu_opc_a, alu_m_a, alu_n_a, alu_c_a);
   assign alu_neg_a = alu_f_a[15];
   assign alu_zer_a = (alu_f_a == 16'h0000);

   alu_sequencer #(.WIDTH(16), .SETTLE(1)) dut_a (
      .clk(clk), .rst(rst_a),
      .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_opc(cmd_opc_a),
      .cmd_m(cmd_m_a), .cmd_n(cmd_n_a), .cmd_c(cmd_c_a), .cmd_acc(cmd_acc_a),
      .alu_m(alu_m_a), .alu_n(alu_n_a), .alu_c(alu_c_a), .alu_opc(alu_opc_a),
      .alu_f(alu_f_a), .alu_neg(alu_neg_a), .alu_zer(alu_zer_a),
      .res_valid(res_valid_a), .res_ready(res_ready_a), .res_data(res_data_a),
      .res_neg(res_neg_a), .res_zer(res_zer_a), .acc(acc_a), .op_cnt(op_cnt_a)
   );

   // ---------------- instance B: SETTLE = 4 ----------------
   logic        rst_b, cmd_valid_b, cmd_ready_b, cmd_c_b, cmd_acc_b;
   logic [2:0]  cmd_opc_b, alu_opc_b;
   logic [15:0] cmd_m_b, cmd_n_b, alu_m_b, alu_n_b, alu_f_b;
   logic        alu_c_b, alu_neg_b, alu_zer_b;
   logic        res_valid_b, res_ready_b, res_neg_b, res_zer_b;
   logic [15:0] res_data_b, acc_b;
   logic [7:0]  op_cnt_b;
   logic        b_force;
   logic [15:0] b_force_val;

   assign alu_f_b   = b_force ? b_force_val : alu_fn(alu_opc_b, alu_m_b, alu_n_b, alu_c_b);
   assign alu_neg_b = alu_f_b[15];
   assign alu_zer_b = (alu_f_b == 16'h0000);

   alu_sequencer #(.WIDTH(16), .SETTLE(4)) dut_b (
      .clk(clk), .rst(rst_b),
      .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_opc(cmd_opc_b),
      .cmd_m(cmd_m_b), .cmd_n(cmd_n_b), .cmd_c(cmd_c_b), .cmd_acc(cmd_acc_b),
      .alu_m(alu_m_b), .alu_n(alu_n_b), .alu_c(alu_c_b), .alu_opc(alu_opc_b),
      .alu_f(alu_f_b), .alu_neg(alu_neg_b), .alu_zer(alu_zer_b),
      .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b),
      .res_neg(res_neg_b), .res_zer(res_zer_b), .acc(acc_b), .op_cnt(op_cnt_b)
   );

   // Command-level model of instance A.
   logic [15:0] m_acc_a;
   logic [7:0]  m_cnt_a;

   // One complete operation on A. Called just after an edge with A idle.
   // hold: cycles res_ready stays low after capture. pend: keep a follow-up command
   // (opc 4, M 0F0F, N 00FF) waiting on cmd_valid during the hold.
   task automatic op_a(input logic [2:0] opc, input logic [15:0] m, input logic [15:0] n,
                       input logic c, input logic accf, input int hold, input bit pend);
      logic [15:0] em, ef;
      em = accf ? m_acc_a : m;
      ef = alu_fn(opc, em, n, c);
      check("a_cmd_ready_idle", cmd_ready_a, 1);
      cmd_valid_a = 1'b1; cmd_opc_a = opc; cmd_m_a = m; cmd_n_a = n;
      cmd_c_a = c; cmd_acc_a = accf; res_ready_a = (hold == 0);
      @(posedge clk); #1;
      cmd_valid_a = 1'b0; cmd_m_a = 16'($urandom);
      check("a_alu_m", alu_m_a, em);
      check("a_alu_n", alu_n_a, n);
      check("a_alu_c", alu_c_a, c);
      check("a_alu_opc", alu_opc_a, opc);
      check("a_res_valid_drive", res_valid_a, 0);
      check("a_cmd_ready_drive", cmd_ready_a, 0);
      @(posedge clk); #1;
      m_acc_a = ef;
      m_cnt_a = m_cnt_a + 8'd1;
      check("a_res_valid", res_valid_a, 1);
      check("a_res_data", res_data_a, ef);
      check("a_res_neg", res_neg_a, ef[15]);
      check("a_res_zer", res_zer_a, (ef == 16'h0000));
      check("a_acc", acc_a, m_acc_a);
      check("a_op_cnt", op_cnt_a, m_cnt_a);
      if (pend) begin
         cmd_valid_a = 1'b1; cmd_opc_a = 3'd4; cmd_m_a = 16'h0F0F;
         cmd_n_a = 16'h00FF; cmd_c_a = 1'b0; cmd_acc_a = 1'b0;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("a_hold_valid", res_valid_a, 1);
         check("a_hold_data", res_data_a, ef);
         check("a_hold_alu_m", alu_m_a, em);
         check("a_hold_alu_opc", alu_opc_a, opc);
         check("a_hold_cmd_ready", cmd_ready_a, 0);
         if (i == hold - 1) res_ready_a = 1'b1;
      end
      @(posedge clk); #1;
      check("a_after_valid", res_valid_a, 0);
      check("a_after_cmd_ready", cmd_ready_a, 1);
      check("a_after_alu_m", alu_m_a, em);
   endtask

   initial begin
      // ---------- reset state ----------
      rst_a = 1'b1; rst_b = 1'b1;
      cmd_valid_a = 1'b0; cmd_opc_a = 3'd0; cmd_m_a = 16'h0; cmd_n_a = 16'h0;
      cmd_c_a = 1'b0; cmd_acc_a = 1'b0; res_ready_a = 1'b1;
      cmd_valid_b = 1'b0; cmd_opc_b = 3'd0; cmd_m_b = 16'h0; cmd_n_b = 16'h0;
      cmd_c_b = 1'b0; cmd_acc_b = 1'b0; res_ready_b = 1'b1;
      b_force = 1'b0; b_force_val = 16'h0;
      m_acc_a = 16'h0; m_cnt_a = 8'd0;
      #1;
      check("rst_cmd_ready", cmd_ready_a, 0);
      check("rst_res_valid", res_valid_a, 0);
      check("rst_alu_m", alu_m_a, 0);
      check("rst_res_data", res_data_a, 0);
      check("rst_acc", acc_a, 0);
      check("rst_op_cnt", op_cnt_a, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_a = 1'b0; rst_b = 1'b0;
      #1;

      // ---------- directed operations on A ----------
      op_a(3'd0, 16'd5, 16'd3, 1'b1, 1'b0, 0, 1'b0);        // 5+3+1 = 9
      op_a(3'd2, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 0, 1'b0);  // signed max -> 1
      op_a(3'd3, 16'h4000, 16'h0000, 1'b0, 1'b0, 0, 1'b0);  // 3*M -> C000, neg
      op_a(3'd6, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, 1'b0);  // ~M -> 0, zer
      op_a(3'd0, 16'd1, 16'd1, 1'b0, 1'b0, 0, 1'b0);        // 2
      op_a(3'd3, 16'h1234, 16'h0000, 1'b0, 1'b1, 0, 1'b0);  // acc(2)*3 -> 6
      check("chain_acc6", acc_a, 16'd6);
      op_a(3'd5, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 5, 1'b1);  // backpressure, next cmd waiting
      op_a(3'd4, 16'h0F0F, 16'h00FF, 1'b0, 1'b0, 0, 1'b0);  // accepted right after handshake

      // ---------- reset during DRIVE on A ----------
      cmd_valid_a = 1'b1; cmd_opc_a = 3'd0; cmd_m_a = 16'd7; cmd_n_a = 16'd8; cmd_acc_a = 1'b0;
      @(posedge clk); #1;
      cmd_valid_a = 1'b0;
      #2 rst_a = 1'b1;
      #1;
      check("arst_res_valid", res_valid_a, 0);
      check("arst_cmd_ready", cmd_ready_a, 0);
      check("arst_alu_m", alu_m_a, 0);
      check("arst_alu_n", alu_n_a, 0);
      check("arst_acc", acc_a, 0);
      check("arst_op_cnt", op_cnt_a, 0);
      check("arst_res_data", res_data_a, 0);
      m_acc_a = 16'h0; m_cnt_a = 8'd0;
      @(posedge clk); #1;
      check("arst_hold_valid", res_valid_a, 0);
      rst_a = 1'b0;
      @(posedge clk); #1;
      check("arst_post_valid", res_valid_a, 0);
      op_a(3'd0, 16'd10, 16'd20, 1'b0, 1'b0, 0, 1'b0);
      check("arst_op_cnt1", op_cnt_a, 1);

      // ---------- random operations on A (covers op_cnt wrap) ----------
      for (int k = 0; k < 280; k++) begin
         op_a(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), 1'b0);
      end
      check("wrap_op_cnt", op_cnt_a, m_cnt_a);

      // ---------- SETTLE = 4 on B: capture timing ----------
      check("b_cmd_ready", cmd_ready_b, 1);
      cmd_valid_b = 1'b1; cmd_opc_b = 3'd5; cmd_m_b = 16'h1234; cmd_n_b = 16'h0;
      @(posedge clk); #1;                                    // accept edge k
      cmd_valid_b = 1'b0;
      check("b_alu_m", alu_m_b, 16'h1234);
      check("b_valid_k", res_valid_b, 0);
      @(posedge clk); #1;
      check("b_valid_k1", res_valid_b, 0);
      @(posedge clk); #1;
      check("b_valid_k2", res_valid_b, 0);
      b_force = 1'b1; b_force_val = 16'hAAAA;                // transient value, must not be captured
      @(posedge clk); #1;
      check("b_valid_k3", res_valid_b, 0);
      b_force_val = 16'h8000;                                // value present at edge k+4
      @(posedge clk); #1;
      check("b_valid_k4", res_valid_b, 1);
      check("b_res_data", res_data_b, 16'h8000);
      check("b_res_neg", res_neg_b, 1);
      check("b_res_zer", res_zer_b, 0);
      check("b_acc", acc_b, 16'h8000);
      check("b_op_cnt", op_cnt_b, 1);
      b_force = 1'b0;
      @(posedge clk); #1;
      check("b_valid_k5", res_valid_b, 0);
      check("b_cmd_ready_k5", cmd_ready_b, 1);

      // ---------- reset during DRIVE on B ----------
      cmd_valid_b = 1'b1; cmd_opc_b = 3'd0; cmd_m_b = 16'd1; cmd_n_b = 16'd1;
      @(posedge clk); #1;
      cmd_valid_b = 1'b0;
      @(posedge clk); #1;
      #2 rst_b = 1'b1;
      #1;
      check("brst_valid", res_valid_b, 0);
      check("brst_acc", acc_b, 0);
      check("brst_op_cnt", op_cnt_b, 0);
      check("brst_alu_m", alu_m_b, 0);
      @(posedge clk); #1;
      rst_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("brst_no_pulse", res_valid_b, 0);
      end
      cmd_valid_b = 1'b1; cmd_opc_b = 3'd0; cmd_m_b = 16'h7777; cmd_n_b = 16'd5;
      cmd_c_b = 1'b0; cmd_acc_b = 1'b1;                      // acc is 0 after reset
      @(posedge clk); #1;
      cmd_valid_b = 1'b0;
      for (int i = 0; i < 4; i++) @(posedge clk);
      #1;
      check("brst_res_valid", res_valid_b, 1);
      check("brst_res_data", res_data_b, 16'd5);
      check("brst_op_cnt1", op_cnt_b, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
